// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Status word exposes count/overrun/busy/full/empty for CPU polling.
module uart_tx_port #(
    parameter int DIVISOR    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic [7:0]  dataIn,
    input  logic        clrOvr,
    output logic        txd,
    output logic        full,
    output logic        empty,
    output logic [31:0] status
);
    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] BAUD_LOAD = 16'(DIVISOR - 1);
    localparam logic [8:0]  DEPTH9    = 9'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [8:0]      count, count_n;
    logic            overrun, busy, push, pop;
    logic [7:0]      shift, shift_n;
    logic [2:0]      bit_idx, bit_n;
    logic [15:0]     baud, baud_n;
    logic            txd_n;

    // full is the registered value, so a write on the popping edge is still dropped
    assign push    = wrEn & ~full;
    assign pop     = (state == IDLE) & ~empty;
    assign busy    = (state != IDLE);
    assign count_n = count + {8'd0, push} - {8'd0, pop};
    assign status  = {15'b0, count, 4'b0, overrun, busy, full, empty};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dataIn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == DEPTH9);
            empty <= (count_n == 9'd0);
            if (wrEn & full)  overrun <= 1'b1;
            else if (clrOvr)  overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_idx <= bit_n;
            baud    <= baud_n;
            txd     <= txd_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_idx;
        baud_n  = baud;
        case (state)
            IDLE: begin
                if (pop) begin
                    shift_n = mem[rd_ptr];
                    baud_n  = BAUD_LOAD;
                    bit_n   = 3'd0;
                    state_n = START;
                end
            end
            START: begin
                if (baud == 16'd0) begin
                    baud_n  = BAUD_LOAD;
                    state_n = DATA;
                end else begin
                    baud_n = baud - 16'd1;
                end
            end
            DATA: begin
                if (baud == 16'd0) begin
                    baud_n = BAUD_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        shift_n = shift >> 1;
                        bit_n   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud - 16'd1;
                end
            end
            STOP: begin
                if (baud == 16'd0) begin
                    baud_n  = BAUD_LOAD;
                    state_n = IDLE;
                end else begin
                    baud_n = baud - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Line level is registered from the next state so txd never glitches
        if (state_n == START)     txd_n = 1'b0;
        else if (state_n == DATA) txd_n = shift_n[0];
        else                      txd_n = 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port (DIVISOR=4, FIFO_DEPTH=4): cycle-exact
// frame waveforms, FIFO fill/overflow, push at the popping edge, mid-frame reset.
module tb_uart_tx_port;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst, wrEn, clrOvr;
    logic [7:0]  dataIn;
    logic        txd, full, empty;
    logic [31:0] status;
    int          checks = 0;
    int          failures = 0;

    uart_tx_port #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .dataIn(dataIn), .clrOvr(clrOvr),
        .txd(txd), .full(full), .empty(empty), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at the negedge of the first start-bit cycle; returns at the
    // negedge just after the stop bit (the idle cycle).
    task automatic frame(input string tag, input logic [7:0] b);
        int         bad = 0;
        logic [7:0] dec = '0;
        logic       e;
        for (int k = 0; k < 10*DIV; k++) begin
            if (k < DIV)         e = 1'b0;
            else if (k < 9*DIV)  e = b[3'((k-DIV)/DIV)];
            else                 e = 1'b1;
            if (txd !== e || status[2] !== 1'b1) bad++;
            if (k >= DIV && k < 9*DIV && ((k-DIV) % DIV) == 2) dec[3'((k-DIV)/DIV)] = txd;
            @(negedge clk);
        end
        chk({tag, "_wave"}, bad, 0);
        chk({tag, "_byte"}, {24'd0, dec}, {24'd0, b});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int bad;
        rst = 1'b1; wrEn = 1'b0; clrOvr = 1'b0; dataIn = '0;
        repeat (3) @(negedge clk);
        chk("rst_status", status, 32'h1);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte A5
        wrEn = 1'b1; dataIn = 8'hA5;
        @(negedge clk);                                  // cycle 0
        wrEn = 1'b0;
        chk("single_c0_count", {23'd0, status[16:8]}, 32'd1);
        chk("single_c0_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);                                  // cycle 1
        frame("single", 8'hA5);                          // ends at cycle 41
        chk("single_c41_status", status, 32'h1);
        chk("single_c41_txd", {31'd0, txd}, 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back 55, 0F
        wrEn = 1'b1; dataIn = 8'h55;
        @(negedge clk);                                  // cycle 0
        dataIn = 8'h0F;
        chk("b2b_c0_count", {23'd0, status[16:8]}, 32'd1);
        @(negedge clk);                                  // cycle 1
        wrEn = 1'b0;
        chk("b2b_c1_count", {23'd0, status[16:8]}, 32'd1);
        frame("b2b_first", 8'h55);
        chk("b2b_gap_busy", {31'd0, status[2]}, 32'd0);
        chk("b2b_gap_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        frame("b2b_second", 8'h0F);
        chk("b2b_end_status", status, 32'h1);
        repeat (2) @(negedge clk);

        // Fill / overflow
        wrEn = 1'b1; dataIn = 8'h11;
        fork
            begin
                repeat (2) @(negedge clk);
                frame("ovf_11", 8'h11);
            end
            begin
                q = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
                foreach (q[i]) begin
                    @(negedge clk);
                    dataIn = q[i];
                end
                // cycle 4: 22..55 queued, 66 about to be sampled
                chk("ovf_c4_count", {23'd0, status[16:8]}, 32'd4);
                chk("ovf_c4_full", {31'd0, full}, 32'd1);
                chk("ovf_c4_ovr", {31'd0, status[3]}, 32'd0);
                @(negedge clk);
                wrEn = 1'b0;
                chk("ovf_c5_status", status, 32'h0000_040E);
                clrOvr = 1'b1;
                @(negedge clk);
                clrOvr = 1'b0;
                chk("clr_ovr", {31'd0, status[3]}, 32'd0);
                chk("clr_full", {31'd0, full}, 32'd1);
            end
        join
        // Idle cycle with FIFO full: write lands on the popping edge
        chk("pp_idle_full", {31'd0, full}, 32'd1);
        wrEn = 1'b1; dataIn = 8'h77;
        fork
            begin
                @(negedge clk);
                frame("ovf_22", 8'h22);
            end
            begin
                @(negedge clk);
                dataIn = 8'h88;
                chk("pp_count", {23'd0, status[16:8]}, 32'd3);
                chk("pp_ovr", {31'd0, status[3]}, 32'd1);
                chk("pp_full", {31'd0, full}, 32'd0);
                @(negedge clk);
                wrEn = 1'b0;
                chk("pp_next_count", {23'd0, status[16:8]}, 32'd4);
                chk("pp_next_full", {31'd0, full}, 32'd1);
            end
        join
        q = '{8'h33, 8'h44, 8'h55, 8'h88};
        foreach (q[i]) begin
            chk($sformatf("ovf_gap%0d", i), {31'd0, status[2]}, 32'd0);
            @(negedge clk);
            frame($sformatf("ovf_q%0d", i), q[i]);
        end
        chk("ovf_end_status", status, 32'h9);
        clrOvr = 1'b1;
        @(negedge clk);
        clrOvr = 1'b0;
        chk("ovf_clr_status", status, 32'h1);
        @(negedge clk);

        // Reset mid-frame during data bit 3 of FF
        wrEn = 1'b1; dataIn = 8'hFF;
        @(negedge clk);                                  // cycle 0
        dataIn = 8'h81;
        @(negedge clk);                                  // cycle 1
        dataIn = 8'h3C;
        @(negedge clk);                                  // cycle 2
        wrEn = 1'b0;
        repeat (15) @(negedge clk);                      // cycle 17
        chk("mid_c17_txd", {31'd0, txd}, 32'd1);
        chk("mid_c17_count", {23'd0, status[16:8]}, 32'd2);
        rst = 1'b1;
        @(negedge clk);                                  // cycle 18
        rst = 1'b0;
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_status", status, 32'h1);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1 || status !== 32'h1) bad++;
        end
        chk("mid_quiet", bad, 0);
        wrEn = 1'b1; dataIn = 8'hC3;
        @(negedge clk);
        wrEn = 1'b0;
        @(negedge clk);
        frame("post_rst", 8'hC3);
        chk("post_rst_status", status, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
